// File: rtl/nn_pkg.sv
// nn_pkg: shared widths and FSM state encoding for the weight/bias fetch path.
package nn_pkg;
  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 15;
  localparam int BADDR_W    = 9;
  localparam int MAX_LAYERS = 5;
  localparam int NW         = 6;
  localparam int KW         = $clog2(MAX_LAYERS);
  typedef enum logic [2:0] {IDLE, PRECOMP, READY, BURST, DRAIN} state_t;
endpackage

// File: rtl/layer_base_table.sv
// layer_base_table: accumulates per-layer weight/bias ROM base addresses one layer per step
// and serves base lookup by layer index.
module layer_base_table
  import nn_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_clear,
  input  logic                          i_step,
  input  logic [MAX_LAYERS-1:0][NW-1:0] i_nl,
  input  logic [NW-1:0]                 i_no_layers,
  input  logic [NW-1:0]                 i_n,
  output logic                          o_last,
  output logic                          o_ovf,
  output logic [ADDR_W-1:0]             o_wbase,
  output logic [BADDR_W-1:0]            o_bbase
);
  logic [KW-1:0]      r_k;
  logic [ADDR_W:0]    r_wacc;
  logic [BADDR_W:0]   r_bacc;
  logic [ADDR_W-1:0]  r_wbase [MAX_LAYERS];
  logic [BADDR_W-1:0] r_bbase [MAX_LAYERS];
  logic [NW-1:0]      w_nl;
  logic [2*NW-1:0]    w_sq;
  logic [ADDR_W:0]    w_wnext;
  logic [BADDR_W:0]   w_bnext;
  logic               w_n_ok;

  assign w_nl    = i_nl[r_k];
  assign w_sq    = w_nl * w_nl;
  assign w_wnext = r_wacc + {{(ADDR_W+1-2*NW){1'b0}}, w_sq};
  assign w_bnext = r_bacc + {{(BADDR_W+1-NW){1'b0}}, w_nl};
  // Running totals may reach exactly the ROM size; only going past it is an overflow.
  assign o_ovf   = (w_wnext > {1'b1, {ADDR_W{1'b0}}}) || (w_bnext > {1'b1, {BADDR_W{1'b0}}});
  assign o_last  = (int'(r_k) + 1 >= int'(i_no_layers)) || (r_k == KW'(MAX_LAYERS - 1));
  assign w_n_ok  = i_n < NW'(MAX_LAYERS);
  assign o_wbase = w_n_ok ? r_wbase[i_n[KW-1:0]] : '0;
  assign o_bbase = w_n_ok ? r_bbase[i_n[KW-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_k    <= '0;
      r_wacc <= '0;
      r_bacc <= '0;
      for (int k = 0; k < MAX_LAYERS; k++) begin
        r_wbase[k] <= '0;
        r_bbase[k] <= '0;
      end
    end else if (i_step) begin
      r_wbase[r_k] <= r_wacc[ADDR_W-1:0];
      r_bbase[r_k] <= r_bacc[BADDR_W-1:0];
      r_wacc       <= w_wnext;
      r_bacc       <= w_bnext;
      r_k          <= o_last ? r_k : r_k + 1'b1;
    end
  end
endmodule

// File: rtl/weight_bias_fetch.sv
// weight_bias_fetch: on each weight_en rising edge streams one neuron's weights (one per cycle)
// and its bias from synchronous ROMs to the MAC datapath.
module weight_bias_fetch
  import nn_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [NW-1:0]      no_layers,
  input  logic [NW-1:0]      nl1,
  input  logic [NW-1:0]      nl2,
  input  logic [NW-1:0]      nl3,
  input  logic [NW-1:0]      nl4,
  input  logic [NW-1:0]      nl5,
  input  logic               weight_en,
  input  logic [NW-1:0]      n,
  input  logic [NW-1:0]      i,
  output logic [ADDR_W-1:0]  w_addr,
  output logic               w_rd,
  input  logic [DATA_W-1:0]  w_rdata,
  output logic [BADDR_W-1:0] b_addr,
  output logic               b_rd,
  input  logic [DATA_W-1:0]  b_rdata,
  output logic [DATA_W-1:0]  weight_out,
  output logic               weight_valid,
  output logic [NW-1:0]      weight_idx,
  output logic [DATA_W-1:0]  bias_out,
  output logic               bias_valid,
  output logic               ready,
  output logic               burst_done,
  output logic               fetch_err
);
  state_t                        r_state;
  logic                          r_we_prev;
  logic [NW-1:0]                 r_j;
  logic [NW-1:0]                 r_nl;
  logic [MAX_LAYERS-1:0][NW-1:0] w_nls;
  logic [NW-1:0]                 w_nl_n;
  logic [2*NW-1:0]               w_prod;
  logic [ADDR_W-1:0]             w_wbase;
  logic [ADDR_W-1:0]             w_row;
  logic [BADDR_W-1:0]            w_bbase;
  logic                          w_rise;
  logic                          w_n_bad;
  logic                          w_last;
  logic                          w_ovf;
  logic                          w_step;

  assign w_nls      = {nl5, nl4, nl3, nl2, nl1};
  assign w_n_bad    = (n >= no_layers) || (n >= NW'(MAX_LAYERS));
  assign w_nl_n     = w_n_bad ? '0 : w_nls[n[KW-1:0]];
  assign w_prod     = i * w_nl_n;
  assign w_row      = w_wbase + ADDR_W'(w_prod);
  assign w_rise     = weight_en && !r_we_prev;
  assign w_step     = (r_state == PRECOMP) && !start;
  // ROM data lands one cycle after the strobe, aligned with the registered valid flags.
  assign weight_out = weight_valid ? w_rdata : '0;
  assign bias_out   = bias_valid ? b_rdata : '0;

  layer_base_table u_tbl (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (start),
    .i_step      (w_step),
    .i_nl        (w_nls),
    .i_no_layers (no_layers),
    .i_n         (n),
    .o_last      (w_last),
    .o_ovf       (w_ovf),
    .o_wbase     (w_wbase),
    .o_bbase     (w_bbase)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_we_prev    <= 1'b0;
      r_j          <= '0;
      r_nl         <= '0;
      w_rd         <= 1'b0;
      w_addr       <= '0;
      b_rd         <= 1'b0;
      b_addr       <= '0;
      weight_valid <= 1'b0;
      weight_idx   <= '0;
      bias_valid   <= 1'b0;
      ready        <= 1'b0;
      burst_done   <= 1'b0;
      fetch_err    <= 1'b0;
    end else begin
      r_we_prev    <= weight_en;
      weight_valid <= w_rd;
      weight_idx   <= r_j;
      bias_valid   <= b_rd;
      b_rd         <= 1'b0;
      burst_done   <= 1'b0;
      if (start) begin
        r_state   <= PRECOMP;
        fetch_err <= 1'b0;
        ready     <= 1'b0;
        w_rd      <= 1'b0;
      end else begin
        case (r_state)
          PRECOMP: begin
            if (w_ovf) begin
              fetch_err <= 1'b1;
              r_state   <= IDLE;
            end else if (w_last) begin
              ready   <= 1'b1;
              r_state <= READY;
            end
          end
          READY: begin
            if (w_rise) begin
              if (w_n_bad) fetch_err <= 1'b1;
              else if (w_nl_n == '0) burst_done <= 1'b1;
              else if (i >= w_nl_n) fetch_err <= 1'b1;
              else begin
                r_state <= BURST;
                w_rd    <= 1'b1;
                w_addr  <= w_row;
                b_rd    <= 1'b1;
                b_addr  <= w_bbase + BADDR_W'(i);
                r_j     <= '0;
                r_nl    <= w_nl_n;
              end
            end
          end
          BURST: begin
            if (!weight_en) begin
              w_rd    <= 1'b0;
              r_state <= READY;
            end else if (r_j == r_nl - 1'b1) begin
              w_rd       <= 1'b0;
              burst_done <= 1'b1;
              r_state    <= DRAIN;
            end else begin
              w_addr <= w_addr + 1'b1;
              r_j    <= r_j + 1'b1;
            end
          end
          DRAIN:   r_state <= READY;
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_weight_bias_fetch.sv
// tb_weight_bias_fetch: randomized scoreboard bench; expected ROM traffic and outputs come
// from layer-size arithmetic, checked by an independent negedge monitor.
module tb_weight_bias_fetch;
  logic        clk = 0, rst = 1, start = 0, weight_en = 0;
  logic [5:0]  no_layers = 0, nl1 = 0, nl2 = 0, nl3 = 0, nl4 = 0, nl5 = 0, n = 0, i = 0;
  logic [14:0] w_addr;
  logic [8:0]  b_addr;
  logic        w_rd, b_rd, weight_valid, bias_valid, ready, burst_done, fetch_err;
  logic [15:0] w_rdata = 0, b_rdata = 0, weight_out, bias_out;
  logic [5:0]  weight_idx;

  typedef struct { int w; int idx; bit bv; int b; bit done; } exp_t;
  exp_t q_out[$];
  int   q_wa[$];
  int   q_ba[$];
  int   cfg_no;
  int   cfg_nl[5];
  bit   exp_err;
  int   n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  weight_bias_fetch dut (
    .clk(clk), .rst(rst), .start(start), .no_layers(no_layers),
    .nl1(nl1), .nl2(nl2), .nl3(nl3), .nl4(nl4), .nl5(nl5),
    .weight_en(weight_en), .n(n), .i(i),
    .w_addr(w_addr), .w_rd(w_rd), .w_rdata(w_rdata),
    .b_addr(b_addr), .b_rd(b_rd), .b_rdata(b_rdata),
    .weight_out(weight_out), .weight_valid(weight_valid), .weight_idx(weight_idx),
    .bias_out(bias_out), .bias_valid(bias_valid), .ready(ready),
    .burst_done(burst_done), .fetch_err(fetch_err)
  );

  function automatic int wrom(input int a); return (a * 40503 + 7) & 16'hFFFF; endfunction
  function automatic int brom(input int a); return (a * 9973 + 12345) & 16'hFFFF; endfunction

  always @(posedge clk) begin
    if (w_rd) w_rdata <= 16'(wrom(int'(w_addr)));
    if (b_rd) b_rdata <= 16'(brom(int'(b_addr)));
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (w_rd) begin
      if (q_wa.size() == 0) chk("w_rd_spurious", int'(w_rd), 0);
      else chk("w_addr", int'(w_addr), q_wa.pop_front());
    end
    if (b_rd) begin
      if (q_ba.size() == 0) chk("b_rd_spurious", int'(b_rd), 0);
      else chk("b_addr", int'(b_addr), q_ba.pop_front());
    end
    if (weight_valid) begin : pop
      exp_t e;
      if (q_out.size() == 0) chk("weight_valid_spurious", int'(weight_valid), 0);
      else begin
        e = q_out.pop_front();
        chk("weight_out", int'(weight_out), e.w);
        chk("weight_idx", int'(weight_idx), e.idx);
        chk("bias_valid", int'(bias_valid), int'(e.bv));
        if (e.bv) chk("bias_out", int'(bias_out), e.b);
        chk("burst_done", int'(burst_done), int'(e.done));
      end
    end else if (bias_valid || burst_done) chk("stray_bias_or_done", int'(bias_valid) + int'(burst_done), 0);
  end

  function automatic int wbase_of(input int ln);
    int s = 0;
    for (int k = 0; k < ln; k++) s += cfg_nl[k] * cfg_nl[k];
    return s;
  endfunction

  function automatic int bbase_of(input int ln);
    int s = 0;
    for (int k = 0; k < ln; k++) s += cfg_nl[k];
    return s;
  endfunction

  task automatic wait_drain();
    for (int c = 0; c < 200 && (q_wa.size() + q_ba.size() + q_out.size()) != 0; c++) @(posedge clk);
    #1 chk("queues_drained", q_wa.size() + q_ba.size() + q_out.size(), 0);
  endtask

  task automatic check_zero();
    chk("rst_w_rd", int'(w_rd), 0);           chk("rst_b_rd", int'(b_rd), 0);
    chk("rst_w_addr", int'(w_addr), 0);       chk("rst_b_addr", int'(b_addr), 0);
    chk("rst_weight_valid", int'(weight_valid), 0); chk("rst_weight_out", int'(weight_out), 0);
    chk("rst_weight_idx", int'(weight_idx), 0);     chk("rst_bias_valid", int'(bias_valid), 0);
    chk("rst_bias_out", int'(bias_out), 0);   chk("rst_ready", int'(ready), 0);
    chk("rst_burst_done", int'(burst_done), 0);     chk("rst_fetch_err", int'(fetch_err), 0);
  endtask

  task automatic precompute(input int no, input int a, input int b, input int c, input int d, input int e);
    int cyc = 0;
    cfg_no = no;
    cfg_nl = '{a, b, c, d, e};
    no_layers = 6'(no); nl1 = 6'(a); nl2 = 6'(b); nl3 = 6'(c); nl4 = 6'(d); nl5 = 6'(e);
    start = 1;
    @(posedge clk);
    #1 start = 0;
    exp_err = 0;
    chk("ready_drop", int'(ready), 0);
    while (!ready && cyc < 20) begin
      @(posedge clk);
      #1 cyc++;
    end
    chk("precomp_cycles", cyc, no);
    chk("fetch_err_clear", int'(fetch_err), 0);
  endtask

  // m = 0 for a full burst, otherwise weight_en is dropped after m reads (m < layer size).
  task automatic burst(input int bn, input int bi, input int m);
    int nl, row, bb;
    bit bad;
    exp_t e;
    nl  = (bn < 5) ? cfg_nl[bn] : 0;
    bad = bn >= cfg_no || bi >= nl;
    n = 6'(bn);
    i = 6'(bi);
    if (bad) exp_err = 1;
    else begin
      row = wbase_of(bn) + bi * nl;
      bb  = bbase_of(bn) + bi;
      q_ba.push_back(bb);
      for (int j = 0; j < ((m > 0) ? m : nl); j++) begin
        q_wa.push_back(row + j);
        e.w = wrom(row + j); e.idx = j; e.bv = (j == 0); e.b = brom(bb);
        e.done = (m == 0) && (j == nl - 1);
        q_out.push_back(e);
      end
    end
    weight_en = 1;
    repeat ((bad || m == 0) ? nl + 2 : m) @(posedge clk);
    #1 weight_en = 0;
    repeat (2) @(posedge clk);
    #1;
    wait_drain();
    chk("fetch_err", int'(fetch_err), int'(exp_err));
    chk("ready_after_burst", int'(ready), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int no, bn, bi, nl, m;
    int a[5];
    repeat (3) @(posedge clk);
    #1 check_zero();
    rst = 0;
    precompute(3, 4, 3, 2, 0, 0);
    burst(1, 2, 0);
    burst(0, 3, 0);
    burst(2, 1, 0);
    burst(3, 0, 0);
    precompute(3, 4, 3, 2, 0, 0);
    burst(0, 4, 0);
    precompute(2, 1, 5, 0, 0, 0);
    burst(0, 0, 0);
    burst(1, 4, 0);
    precompute(3, 4, 3, 2, 0, 0);
    burst(0, 1, 2);
    burst(0, 1, 0);
    // reset two reads into a burst: only the first read's data emerges
    q_wa.push_back(4); q_wa.push_back(5); q_ba.push_back(1);
    q_out.push_back('{wrom(4), 0, 1'b1, brom(1), 1'b0});
    n = 0; i = 1; weight_en = 1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 check_zero();
    weight_en = 0;
    @(posedge clk);
    #1 rst = 0;
    wait_drain();
    for (int t = 0; t < 25; t++) begin
      no = $urandom_range(1, 5);
      for (int k = 0; k < 5; k++) a[k] = $urandom_range(1, 63);
      precompute(no, a[0], a[1], a[2], a[3], a[4]);
      for (int b = 0; b < 6; b++) begin
        bn = $urandom_range(0, no - 1);
        nl = a[bn];
        bi = $urandom_range(0, nl - 1);
        m = 0;
        if ($urandom_range(0, 7) == 0) begin
          if ($urandom_range(0, 1) == 1) bn = $urandom_range(no, 63);
          else bi = $urandom_range(nl, 63);
        end else if (nl >= 2 && $urandom_range(0, 5) == 0) m = $urandom_range(1, nl - 1);
        burst(bn, bi, m);
        if (exp_err) precompute(no, a[0], a[1], a[2], a[3], a[4]);
      end
    end
    wait_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
